// File: rtl/sequenciador_banco.sv
// ============================================================================
// sequenciador_banco : command sequencer driving a 4-entry, 2-read-port bank.
// Optional SEQ_FLAGS_EN adds registered zero/carry outputs.  Rev 1.0
// ============================================================================
`default_nettype none

module sequenciador_banco #(
  parameter int Size = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [1:0]      dst,
  input  logic [1:0]      src,
  input  logic [Size-1:0] imm,
  output logic            busy,
  output logic            done,
  output logic [1:0]      bank_a1,
  output logic [1:0]      bank_a2,
  output logic            bank_we,
  output logic [Size-1:0] bank_wd,
  input  logic [Size-1:0] bank_rd1,
  input  logic [Size-1:0] bank_rd2
`ifdef SEQ_FLAGS_EN
  ,
  output logic            zero,
  output logic            carry
`endif
);

  localparam logic [1:0] c_OP_LOAD = 2'b00;
  localparam logic [1:0] c_OP_MOV  = 2'b01;
  localparam logic [1:0] c_OP_ADD  = 2'b10;
  localparam logic [1:0] c_OP_SUB  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_op;
  logic [1:0]      r_dst;
  logic [1:0]      r_src;
  logic [Size-1:0] r_imm;
  logic [Size-1:0] r_opa;
  logic [Size-1:0] r_opb;
  logic [Size:0]   r_res;
  logic [Size:0]   w_sum;
  logic [Size:0]   w_diff;
  logic [Size:0]   w_res;

  assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
  // The extra top bit of the difference is the borrow (opA < opB).
  assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};

  always_comb begin
    w_res = '0;
    case (r_op)
      c_OP_LOAD: w_res = {1'b0, r_imm};
      c_OP_MOV:  w_res = {1'b0, r_opb};
      c_OP_ADD:  w_res = w_sum;
      c_OP_SUB:  w_res = w_diff;
      default:   w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    bank_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_READ;
      end
      S_READ:  w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_WRITE;
      S_WRITE: begin
        bank_we     = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read and write addresses are both the latched dst/src, so they simply follow them.
  assign bank_a1 = r_dst;
  assign bank_a2 = r_src;
  assign bank_wd = r_res[Size-1:0];

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_dst   <= '0;
      r_src   <= '0;
      r_imm   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_dst <= dst;
            r_src <= src;
            r_imm <= imm;
          end
        end
        S_READ: begin
          r_opa <= bank_rd1;
          r_opb <= bank_rd2;
        end
        S_EXEC:  r_res <= w_res;
        default: ;
      endcase
    end
  end

`ifdef SEQ_FLAGS_EN
  logic r_zero;
  logic r_carry;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_zero  <= (w_res[Size-1:0] == '0);
      r_carry <= (r_op == c_OP_ADD || r_op == c_OP_SUB) ? w_res[Size] : 1'b0;
    end
  end

  assign zero  = r_zero;
  assign carry = r_carry;
`else
  logic w_unused_res_msb;
  assign w_unused_res_msb = r_res[Size];
`endif

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_banco.sv
// Self-checking bench for sequenciador_banco with a behavioural 4-entry bank.
`default_nettype none

module tb_sequenciador_banco;

  localparam int Size = 8;

  logic            clk = 1'b0;
  logic            clr;
  logic            start;
  logic [1:0]      op;
  logic [1:0]      dst;
  logic [1:0]      src;
  logic [Size-1:0] imm;
  logic            busy;
  logic            done;
  logic [1:0]      bank_a1;
  logic [1:0]      bank_a2;
  logic            bank_we;
  logic [Size-1:0] bank_wd;
  logic [Size-1:0] bank_rd1;
  logic [Size-1:0] bank_rd2;
`ifdef SEQ_FLAGS_EN
  logic            zero;
  logic            carry;
`endif

  sequenciador_banco #(.Size(Size)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .op       (op),
    .dst      (dst),
    .src      (src),
    .imm      (imm),
    .busy     (busy),
    .done     (done),
    .bank_a1  (bank_a1),
    .bank_a2  (bank_a2),
    .bank_we  (bank_we),
    .bank_wd  (bank_wd),
    .bank_rd1 (bank_rd1),
    .bank_rd2 (bank_rd2)
`ifdef SEQ_FLAGS_EN
    ,
    .zero     (zero),
    .carry    (carry)
`endif
  );

  always #5 clk = ~clk;

  logic [Size-1:0] m_bank [4];
  always @(posedge clk) if (bank_we) m_bank[bank_a1] <= bank_wd;
  assign bank_rd1 = m_bank[bank_a1];
  assign bank_rd2 = m_bank[bank_a2];

  typedef struct {
    logic [1:0]      op;
    logic [1:0]      dst;
    logic [1:0]      src;
    logic [Size-1:0] imm;
    logic [Size-1:0] exp_wd;
    logic            exp_zero;
    logic            exp_carry;
  } cmd_t;

  int   total = 0;
  int   bad   = 0;
  cmd_t sb[$];
  cmd_t vec[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // pre: start/inputs already driven; hold: keep start high and present nxt after acceptance.
  task automatic do_cmd(input cmd_t c, input bit pre, input bit hold, input cmd_t nxt);
    cmd_t e;
    if (!pre) begin
      @(negedge clk);
      start = 1'b1; op = c.op; dst = c.dst; src = c.src; imm = c.imm;
    end
    @(posedge clk);
    sb.push_back(c);
    #1;
    if (hold) begin
      op = nxt.op; dst = nxt.dst; src = nxt.src; imm = nxt.imm;
    end else begin
      start = 1'b0;
    end
    @(negedge clk);
    chk("c1_busy", busy, 1);
    chk("c1_we", bank_we, 0);
    @(negedge clk);
    chk("c2_we", bank_we, 0);
    chk("c2_done", done, 0);
    @(negedge clk);
    chk("c3_we", bank_we, 1);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      chk("wr_addr", bank_a1, e.dst);
      chk("wr_data", bank_wd, e.exp_wd);
    end
    @(negedge clk);
    chk("c4_done", done, 1);
    chk("c4_busy", busy, 1);
    chk("c4_we", bank_we, 0);
`ifdef SEQ_FLAGS_EN
    chk("zero", zero, c.exp_zero);
    chk("carry", carry, c.exp_carry);
`endif
    @(negedge clk);
    chk("c5_busy", busy, 0);
    chk("c5_done", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    cmd_t a, b, none;
    // op dst src imm exp_wd zero carry
    vec[0]  = '{2'b00, 2'd2, 2'd0, 8'h5A, 8'h5A, 1'b0, 1'b0};
    vec[1]  = '{2'b00, 2'd1, 2'd0, 8'hF0, 8'hF0, 1'b0, 1'b0};
    vec[2]  = '{2'b00, 2'd3, 2'd0, 8'h20, 8'h20, 1'b0, 1'b0};
    vec[3]  = '{2'b10, 2'd1, 2'd3, 8'h00, 8'h10, 1'b0, 1'b1};
    vec[4]  = '{2'b00, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0};
    vec[5]  = '{2'b11, 2'd0, 2'd0, 8'hAA, 8'h00, 1'b1, 1'b0};
    vec[6]  = '{2'b00, 2'd1, 2'd0, 8'h03, 8'h03, 1'b0, 1'b0};
    vec[7]  = '{2'b00, 2'd2, 2'd0, 8'h04, 8'h04, 1'b0, 1'b0};
    vec[8]  = '{2'b11, 2'd1, 2'd2, 8'h00, 8'hFF, 1'b0, 1'b1};
    vec[9]  = '{2'b01, 2'd3, 2'd1, 8'h11, 8'hFF, 1'b0, 1'b0};
    vec[10] = '{2'b10, 2'd2, 2'd2, 8'h00, 8'h08, 1'b0, 1'b0};
    vec[11] = '{2'b11, 2'd2, 2'd3, 8'h00, 8'h09, 1'b0, 1'b1};
    none    = '{2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0};

    clr = 1'b1; start = 1'b1; op = 2'b10; dst = 2'd3; src = 2'd2; imm = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", bank_we, 0);
    chk("rst_a1", bank_a1, 0);
    chk("rst_a2", bank_a2, 0);
    chk("rst_wd", bank_wd, 0);
`ifdef SEQ_FLAGS_EN
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
`endif
    clr = 1'b0; start = 1'b0;

    for (int i = 0; i < 12; i++) do_cmd(vec[i], 1'b0, 1'b0, none);
    chk("bank_r2_after_table", m_bank[2], 8'h09);

    // start held high: second command must wait for IDLE, first result unaffected.
    a = '{2'b00, 2'd0, 2'd0, 8'h77, 8'h77, 1'b0, 1'b0};
    b = '{2'b01, 2'd3, 2'd0, 8'hC3, 8'h77, 1'b0, 1'b0};
    do_cmd(a, 1'b0, 1'b1, b);
    do_cmd(b, 1'b1, 1'b0, none);
    chk("bank_r0_hold", m_bank[0], 8'h77);
    chk("bank_r3_hold", m_bank[3], 8'h77);

    // Abort in EXEC: no write, no done, R2 keeps 09.
    @(negedge clk);
    start = 1'b1; op = 2'b10; dst = 2'd2; src = 2'd2; imm = 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("abort_read_busy", busy, 1);
    @(negedge clk);
    chk("abort_exec_we", bank_we, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_c3_we", bank_we, 0);
    chk("abort_c3_busy", busy, 0);
    chk("abort_a1", bank_a1, 0);
    @(negedge clk);
    chk("abort_c4_done", done, 0);
    chk("abort_c4_we", bank_we, 0);
    chk("abort_r2_kept", m_bank[2], 8'h09);

    a = '{2'b11, 2'd2, 2'd2, 8'h00, 8'h00, 1'b1, 1'b0};
    do_cmd(a, 1'b0, 1'b0, none);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
